cpu_trace_monitor: RTL and testbench
====================================

# cpu_trace_monitor

Synthesizable execution-trace monitor attached beside the single-cycle CPU core. It samples the fetch-stage PC and instruction every clock and keeps the last DEPTH entries in a circular trace buffer. It counts cycles and retired instructions and detects program end (exit syscall or a self-loop) in hardware. Benches and on-FPGA debug use it in place of hand-timed `$finish` delays and per-cycle `$display` dumps.

## Interface
Parameters:
- ADDR_W, 32, PC width
- INSN_W, 32, instruction width
- DEPTH, 16, trace buffer entries; power of two, minimum 2
- STALL_LIMIT, 8, consecutive identical-PC valid samples that declare a self-loop halt; minimum 2
- HALT_INSN, 32'h0000000c, instruction encoding treated as exit (MIPS `syscall`)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low (asserted at 0); clears all state
- clear  in  1  synchronous flush: buffer, counters and FSM return to their reset values
- valid  in  1  pc/insn describe an executing instruction this cycle
- pc  in  ADDR_W  current PC
- insn  in  INSN_W  current instruction
- rd_idx  in  $clog2(DEPTH)  trace read index; 0 = newest entry
- rd_pc  out  ADDR_W  PC at rd_idx; combinational read
- rd_insn  out  INSN_W  instruction at rd_idx; combinational read
- count  out  $clog2(DEPTH)+1  valid entries held; saturates at DEPTH
- cycles  out  32  clocks spent in RUN
- retired  out  32  valid samples recorded
- halted  out  1  FSM is in HALTED
- halt_cause  out  2  0 none, 1 exit instruction, 2 self-loop

## Operation
- FSM states are RUN and HALTED. Reset and clear both enter RUN.
- RUN, each edge:
  - cycles increments.
  - When valid=1: write {pc,insn} at wr_ptr, wr_ptr increments modulo DEPTH, count increments until it saturates at DEPTH, retired increments.
  - Stall tracking, applied only when valid=1:
    - pc equals the last recorded PC: stall_cnt increments.
    - Otherwise: stall_cnt = 1.
    - The first sample after reset or clear sets stall_cnt = 1.
  - valid=0 leaves the buffer, retired and stall_cnt unchanged.
- Halt conditions, evaluated on a RUN sample with valid=1 (the sample is recorded in the same cycle):
  - insn == HALT_INSN: enter HALTED, halt_cause = 1.
  - The updated stall_cnt reaches STALL_LIMIT: enter HALTED, halt_cause = 2.
  - Both true in the same cycle: halt_cause = 1 (exit has priority).
- HALTED:
  - Buffer, count, cycles, retired and halt_cause are frozen; valid is ignored.
  - Only reset or clear leave this state.
- Read port:
  - Entry address = (wr_ptr − 1 − rd_idx) mod DEPTH.
  - When rd_idx ≥ count, rd_pc and rd_insn are 0.
- Counters: cycles and retired saturate at 32'hFFFFFFFF and do not wrap.
- clear and a halt condition in the same cycle: clear wins. The sample is discarded and the FSM stays in RUN.
- clear while HALTED: returns to RUN next edge with everything zeroed.

## Timing
- Reset values:
  - rd_pc = 0, rd_insn = 0 (count = 0)
  - count = 0, cycles = 0, retired = 0
  - halted = 0, halt_cause = 0
  - wr_ptr = 0, stall_cnt = 0
- Reset is asynchronous: assertion mid-operation zeroes outputs immediately, with no clock edge needed. Deassertion is synchronised by the system-level reset synchroniser.
- Write latency: a sample present at edge N is readable at rd_idx=0 immediately after edge N.
- halted, halt_cause: assert immediately after the edge that captures the halting sample. That edge also counts in cycles and retired.
- Read path: combinational from rd_idx and buffer state, with no added latency.
- Buffer wrap: after DEPTH+k recorded samples, the oldest k entries are overwritten. count stays at DEPTH.

## Test plan
- Reset, then 3 valid samples pc=0x0,0x4,0x8 with insn=0x20080001 → count=3, retired=3, rd_idx 0 reads pc 0x8, rd_idx 2 reads pc 0x0, rd_idx 3 reads 0, halted=0.
- DEPTH=16; 20 valid samples pc=4·i → count=16, rd_idx 0 reads pc 0x4C, rd_idx 15 reads pc 0x10 (wrap).
- Samples at pc 0x0, 0x4, then insn=0x0000000c at pc 0x8 → halted=1, halt_cause=1, retired=3. Further valid samples leave retired=3 and cycles frozen.
- STALL_LIMIT=8; pc=0x10 held valid for 8 cycles with a valid=0 gap inside the run → halt after the 8th valid sample, halt_cause=2. 7 samples alone → halted=0.
- Samples interleaved with valid=0 cycles, then clear asserted together with a HALT_INSN sample → halted=0, count=0, cycles=0, retired=0.
- reset driven low between clock edges while halted=1 → all outputs 0 before the next edge. After release, a new sample gives count=1.

Source files
------------

// File: rtl/cpu_trace_monitor.sv
// Execution-trace monitor beside the CPU core: circular PC/instruction history,
// cycle and retire counters, and hardware detection of program end.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_RUN    | sampling: counting cycles, recording valid pc/insn samples
//   S_HALTED | exit insn or self-loop seen; buffer and counters frozen
module cpu_trace_monitor #(
    parameter int                 ADDR_W      = 32,
    parameter int                 INSN_W      = 32,
    parameter int                 DEPTH       = 16,
    parameter int                 STALL_LIMIT = 8,
    parameter logic [INSN_W-1:0]  HALT_INSN   = 32'h0000000c
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       valid,
    input  logic [ADDR_W-1:0]          pc,
    input  logic [INSN_W-1:0]          insn,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [ADDR_W-1:0]          rd_pc,
    output logic [INSN_W-1:0]          rd_insn,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                cycles,
    output logic [31:0]                retired,
    output logic                       halted,
    output logic [1:0]                 halt_cause
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int SW = $clog2(STALL_LIMIT + 1);

    typedef enum logic {
        S_RUN,
        S_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cause_q, cause_d;
    logic [IW-1:0]     wr_ptr;
    logic [CW-1:0]     count_q;
    logic [31:0]       cycles_q;
    logic [31:0]       retired_q;
    logic [SW-1:0]     stall_cnt, stall_next;
    logic [ADDR_W-1:0] last_pc;
    logic              rec;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INSN_W-1:0] insn_mem [DEPTH];

    logic [IW-1:0]     rd_addr;

    always_comb begin
        rec        = (state_q == S_RUN) && valid && !clear;
        // stall_cnt of zero means nothing recorded yet, so the first sample starts a new run
        stall_next = SW'(1);
        if (stall_cnt != '0 && pc == last_pc)
            stall_next = stall_cnt + 1'b1;

        state_d = state_q;
        cause_d = cause_q;
        if (clear) begin
            state_d = S_RUN;
            cause_d = 2'd0;
        end else if (rec) begin
            if (insn == HALT_INSN) begin
                state_d = S_HALTED;
                cause_d = 2'd1;
            end else if (stall_next == SW'(STALL_LIMIT)) begin
                state_d = S_HALTED;
                cause_d = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RUN;
            cause_q   <= 2'd0;
            wr_ptr    <= '0;
            count_q   <= '0;
            cycles_q  <= '0;
            retired_q <= '0;
            stall_cnt <= '0;
            last_pc   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (clear) begin
                wr_ptr    <= '0;
                count_q   <= '0;
                cycles_q  <= '0;
                retired_q <= '0;
                stall_cnt <= '0;
                last_pc   <= '0;
            end else if (state_q == S_RUN) begin
                if (cycles_q != 32'hFFFF_FFFF)
                    cycles_q <= cycles_q + 32'd1;
                if (valid) begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    stall_cnt <= stall_next;
                    last_pc   <= pc;
                    if (count_q != CW'(DEPTH))
                        count_q <= count_q + 1'b1;
                    if (retired_q != 32'hFFFF_FFFF)
                        retired_q <= retired_q + 32'd1;
                end
            end
        end
    end

    // Storage is left unreset; entries beyond count are masked on the read side.
    always_ff @(posedge clk) begin
        if (rec) begin
            pc_mem[wr_ptr]   <= pc;
            insn_mem[wr_ptr] <= insn;
        end
    end

    always_comb begin
        rd_addr = wr_ptr - IW'(1) - rd_idx;
        rd_pc   = '0;
        rd_insn = '0;
        if ({1'b0, rd_idx} < count_q) begin
            rd_pc   = pc_mem[rd_addr];
            rd_insn = insn_mem[rd_addr];
        end
    end

    assign count      = count_q;
    assign cycles     = cycles_q;
    assign retired    = retired_q;
    assign halted     = (state_q == S_HALTED);
    assign halt_cause = cause_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Self-checking bench for cpu_trace_monitor: directed scenarios plus a randomized
// run compared against a queue-based model of the trace history.
module tb_cpu_trace_monitor;

    localparam int DEPTH = 16;
    localparam int LIMIT = 8;
    localparam logic [31:0] HALT = 32'h0000000c;

    logic        clk = 0;
    logic        reset = 0;
    logic        clear = 0;
    logic        valid = 0;
    logic [31:0] pc = 0;
    logic [31:0] insn = 0;
    logic [3:0]  rd_idx = 0;
    logic [31:0] rd_pc, rd_insn;
    logic [4:0]  count;
    logic [31:0] cycles, retired;
    logic        halted;
    logic [1:0]  halt_cause;

    int checks = 0;
    int errors = 0;

    cpu_trace_monitor #(
        .ADDR_W(32), .INSN_W(32), .DEPTH(DEPTH), .STALL_LIMIT(LIMIT), .HALT_INSN(HALT)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .valid(valid), .pc(pc), .insn(insn),
        .rd_idx(rd_idx), .rd_pc(rd_pc), .rd_insn(rd_insn), .count(count),
        .cycles(cycles), .retired(retired), .halted(halted), .halt_cause(halt_cause)
    );

    always #5 clk = ~clk;

    // reference model: newest entry at the front of the queue
    logic [63:0] m_q[$];
    int          m_cycles, m_retired, m_cause, m_stall;
    bit          m_halted, m_have;
    logic [31:0] m_last;

    task automatic model_reset();
        m_q.delete();
        m_cycles = 0; m_retired = 0; m_cause = 0; m_stall = 0;
        m_halted = 0; m_have = 0; m_last = 0;
    endtask

    task automatic model_step(input bit c, input bit v, input logic [31:0] p, input logic [31:0] i);
        if (c) begin
            model_reset();
        end else if (!m_halted) begin
            m_cycles++;
            if (v) begin
                m_q.push_front({p, i});
                if (m_q.size() > DEPTH) void'(m_q.pop_back());
                m_retired++;
                m_stall = (m_have && p == m_last) ? m_stall + 1 : 1;
                m_last = p;
                m_have = 1;
                if (i == HALT) begin
                    m_halted = 1; m_cause = 1;
                end else if (m_stall == LIMIT) begin
                    m_halted = 1; m_cause = 2;
                end
            end
        end
    endtask

    function automatic logic [63:0] model_rd(input int idx);
        return (idx < m_q.size()) ? m_q[idx] : 64'd0;
    endfunction

    task automatic step(input bit c, input bit v, input logic [31:0] p, input logic [31:0] i);
        @(negedge clk);
        clear = c; valid = v; pc = p; insn = i;
        @(posedge clk);
        #1;
        model_step(c, v, p, i);
        clear = 0; valid = 0;
    endtask

    function automatic logic [31:0] plain_insn();
        return $urandom() | 32'h0000_0100;
    endfunction

    task automatic test_reset();
        reset = 0;
        model_reset();
        #12;
        rd_idx = 0; #1;
        checks++;
        if (count !== 5'd0 || cycles !== 32'd0 || retired !== 32'd0 || halted !== 1'b0 ||
            halt_cause !== 2'd0 || rd_pc !== 32'd0 || rd_insn !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: count=%0d cycles=%0d retired=%0d halted=%0b cause=%0d rd_pc=%h rd_insn=%h, required all 0",
                     count, cycles, retired, halted, halt_cause, rd_pc, rd_insn);
        end
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_basic();
        for (int k = 0; k < 3; k++) step(0, 1, 32'(4 * k), 32'h20080001);
        checks++;
        if (count !== 5'd3 || retired !== 32'd3 || halted !== 1'b0) begin
            errors++;
            $display("FAIL basic_counts: count=%0d retired=%0d halted=%0b, required 3 3 0", count, retired, halted);
        end
        rd_idx = 0; #1;
        checks++;
        if (rd_pc !== 32'h8 || rd_insn !== 32'h20080001) begin
            errors++;
            $display("FAIL basic_rd0: pc=%h insn=%h, required 8 20080001", rd_pc, rd_insn);
        end
        rd_idx = 2; #1;
        checks++;
        if (rd_pc !== 32'h0 || rd_insn !== 32'h20080001) begin
            errors++;
            $display("FAIL basic_rd2: pc=%h insn=%h, required 0 20080001", rd_pc, rd_insn);
        end
        rd_idx = 3; #1;
        checks++;
        if (rd_pc !== 32'h0 || rd_insn !== 32'h0) begin
            errors++;
            $display("FAIL basic_rd3_empty: pc=%h insn=%h, required 0 0", rd_pc, rd_insn);
        end
    endtask

    task automatic test_wrap();
        step(1, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(0, 1, 32'(4 * k), plain_insn());
        checks++;
        if (count !== 5'd16 || retired !== 32'd20) begin
            errors++;
            $display("FAIL wrap_count: count=%0d retired=%0d, required 16 20", count, retired);
        end
        rd_idx = 0; #1;
        checks++;
        if (rd_pc !== 32'h4C) begin
            errors++;
            $display("FAIL wrap_rd0: pc=%h, required 4c", rd_pc);
        end
        rd_idx = 15; #1;
        checks++;
        if (rd_pc !== 32'h10 || {rd_pc, rd_insn} !== model_rd(15)) begin
            errors++;
            $display("FAIL wrap_rd15: got %h_%h, required %h", rd_pc, rd_insn, model_rd(15));
        end
    endtask

    task automatic test_exit();
        logic [31:0] cyc_at_halt;
        step(1, 0, 0, 0);
        step(0, 1, 32'h0, plain_insn());
        step(0, 0, 32'h0, 0);
        step(0, 1, 32'h4, plain_insn());
        step(0, 1, 32'h8, HALT);
        checks++;
        if (halted !== 1'b1 || halt_cause !== 2'd1 || retired !== 32'd3 || cycles !== 32'd4) begin
            errors++;
            $display("FAIL exit_halt: halted=%0b cause=%0d retired=%0d cycles=%0d, required 1 1 3 4",
                     halted, halt_cause, retired, cycles);
        end
        cyc_at_halt = cycles;
        for (int k = 0; k < 3; k++) step(0, 1, 32'h100 + 32'(4 * k), plain_insn());
        checks++;
        if (retired !== 32'd3 || cycles !== 32'd4 || count !== 5'd3 || halted !== 1'b1) begin
            errors++;
            $display("FAIL exit_frozen: retired=%0d cycles=%0d count=%0d halted=%0b, required 3 %0d 3 1",
                     retired, cycles, count, halted, cyc_at_halt);
        end
        rd_idx = 0; #1;
        checks++;
        if (rd_pc !== 32'h8 || rd_insn !== HALT) begin
            errors++;
            $display("FAIL exit_rd0: pc=%h insn=%h, required 8 0000000c", rd_pc, rd_insn);
        end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 0);
        step(0, 1, 32'h0C, plain_insn());
        for (int k = 0; k < 7; k++) begin
            step(0, 1, 32'h10, 32'h1000ffff);
            if (k == 3) step(0, 0, 32'h10, 32'h1000ffff);
        end
        checks++;
        if (halted !== 1'b0 || halt_cause !== 2'd0) begin
            errors++;
            $display("FAIL stall_seven: halted=%0b cause=%0d, required 0 0", halted, halt_cause);
        end
        step(0, 1, 32'h10, 32'h1000ffff);
        checks++;
        if (halted !== 1'b1 || halt_cause !== 2'd2 || retired !== 32'd9) begin
            errors++;
            $display("FAIL stall_eight: halted=%0b cause=%0d retired=%0d, required 1 2 9",
                     halted, halt_cause, retired);
        end
        // exit and self-loop on the same sample: exit wins
        step(1, 0, 0, 0);
        for (int k = 0; k < 7; k++) step(0, 1, 32'h20, 32'h1000ffff);
        step(0, 1, 32'h20, HALT);
        checks++;
        if (halted !== 1'b1 || halt_cause !== 2'd1) begin
            errors++;
            $display("FAIL stall_exit_priority: halted=%0b cause=%0d, required 1 1", halted, halt_cause);
        end
    endtask

    task automatic test_clear();
        step(1, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(0, k % 2 == 0, 32'h40 + 32'(4 * k), plain_insn());
        step(1, 1, 32'h80, HALT);
        rd_idx = 0; #1;
        checks++;
        if (halted !== 1'b0 || count !== 5'd0 || cycles !== 32'd0 || retired !== 32'd0 ||
            halt_cause !== 2'd0 || rd_pc !== 32'd0) begin
            errors++;
            $display("FAIL clear_with_halt: halted=%0b count=%0d cycles=%0d retired=%0d cause=%0d rd_pc=%h, required all 0",
                     halted, count, cycles, retired, halt_cause, rd_pc);
        end
        step(0, 1, 32'h84, plain_insn());
        checks++;
        if (count !== 5'd1 || cycles !== 32'd1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL clear_resume: count=%0d cycles=%0d halted=%0b, required 1 1 0", count, cycles, halted);
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, 0);
        step(0, 1, 32'h0, plain_insn());
        step(0, 1, 32'h4, HALT);
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL async_prehalt: halted=%0b, required 1", halted);
        end
        rd_idx = 0;
        @(posedge clk);
        #3;
        reset = 0;
        #1;
        checks++;
        if (halted !== 1'b0 || halt_cause !== 2'd0 || count !== 5'd0 || cycles !== 32'd0 ||
            retired !== 32'd0 || rd_pc !== 32'd0 || rd_insn !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: halted=%0b cause=%0d count=%0d cycles=%0d retired=%0d rd=%h_%h, required all 0",
                     halted, halt_cause, count, cycles, retired, rd_pc, rd_insn);
        end
        model_reset();
        @(negedge clk);
        reset = 1;
        step(0, 1, 32'h200, plain_insn());
        checks++;
        if (count !== 5'd1 || rd_pc !== 32'h200) begin
            errors++;
            $display("FAIL async_after_release: count=%0d rd_pc=%h, required 1 200", count, rd_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] p, i;
        bit          v, c;
        int          halted_for, idx;
        logic [63:0] exp;
        step(1, 0, 0, 0);
        p = 32'h100;
        halted_for = 0;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) p = 32'h100 + 32'(4 * $urandom_range(0, 3));
            i = ($urandom_range(0, 39) == 0) ? HALT : plain_insn();
            c = ($urandom_range(0, 59) == 0) || (halted_for > 5);
            step(c, v, p, i);
            halted_for = m_halted ? halted_for + 1 : 0;
            checks++;
            if (count !== 5'(m_q.size()) || retired !== 32'(m_retired) || cycles !== 32'(m_cycles) ||
                halted !== m_halted || halt_cause !== 2'(m_cause)) begin
                errors++;
                $display("FAIL rand_state[%0d]: count=%0d retired=%0d cycles=%0d halted=%0b cause=%0d, required %0d %0d %0d %0b %0d",
                         n, count, retired, cycles, halted, halt_cause,
                         m_q.size(), m_retired, m_cycles, m_halted, m_cause);
            end
            idx = $urandom_range(0, DEPTH - 1);
            rd_idx = 4'(idx);
            #1;
            exp = model_rd(idx);
            checks++;
            if ({rd_pc, rd_insn} !== exp) begin
                errors++;
                $display("FAIL rand_read[%0d] idx %0d: got %h_%h, required %h", n, idx, rd_pc, rd_insn, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_exit();
        test_stall();
        test_clear();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
